// File: rtl/imm_alu_arbiter_if.sv
// imm_alu_arbiter_if
// Bundles every non-clock signal of the immediate-ALU arbiter: the two
// requester channels, the ALU operand/result bus and the tagged response
// channel.
//   slave  : the arbiter itself.
//   master : its environment (both requesters, the shared ALU and the
//            response consumer).
// Signal summary:
//   req_valid/req_ready [1:0]       per-requester valid/ready, bit i = requester i
//   reqN_instr/reqN_rs1/reqN_imm    requester N operands
//   alu_instr/alu_in1/alu_imm       registered operands driven to the ALU
//   alu_out                         combinational ALU result
//   rsp_valid/rsp_ready             response handshake
//   rsp_id/rsp_data                 owning requester and captured result
//   busy                            arbiter is not idle
interface imm_alu_arbiter_if #(
    parameter int DATA_W = 32
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [31:0]       req0_instr;
    logic [DATA_W-1:0] req0_rs1;
    logic [DATA_W-1:0] req0_imm;
    logic [31:0]       req1_instr;
    logic [DATA_W-1:0] req1_rs1;
    logic [DATA_W-1:0] req1_imm;
    logic [31:0]       alu_instr;
    logic [DATA_W-1:0] alu_in1;
    logic [DATA_W-1:0] alu_imm;
    logic [DATA_W-1:0] alu_out;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;

    modport slave (
        input  req_valid, req0_instr, req0_rs1, req0_imm,
               req1_instr, req1_rs1, req1_imm, alu_out, rsp_ready,
        output req_ready, alu_instr, alu_in1, alu_imm,
               rsp_valid, rsp_id, rsp_data, busy
    );

    modport master (
        output req_valid, req0_instr, req0_rs1, req0_imm,
               req1_instr, req1_rs1, req1_imm, alu_out, rsp_ready,
        input  req_ready, alu_instr, alu_in1, alu_imm,
               rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/imm_alu_arbiter.sv
// imm_alu_arbiter
// Time-shares one combinational immediate-type ALU between two requesters.
// One operation is in flight at a time: a round-robin grant accepts a
// request, its operands are registered onto the ALU for EXEC_CYCLES cycles,
// the result is captured and then offered on a single response channel
// tagged with the owning requester.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    imm_alu_arbiter_if.slave (requests, ALU bus, response, busy)
// Parameters:
//   DATA_W       operand/result width
//   EXEC_CYCLES  ALU settle time in cycles, legal range 1..15
module imm_alu_arbiter #(
    parameter int DATA_W      = 32,
    parameter int EXEC_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    imm_alu_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    state_t            state_reg, state_next;
    logic              ptr_reg, ptr_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic [31:0]       alu_instr_reg, alu_instr_next;
    logic [DATA_W-1:0] alu_in1_reg, alu_in1_next;
    logic [DATA_W-1:0] alu_imm_reg, alu_imm_next;
    logic [DATA_W-1:0] rsp_data_reg, rsp_data_next;
    logic              rsp_id_reg, rsp_id_next;
    logic              rsp_valid_reg, rsp_valid_next;

    logic              grant;
    logic              idle;
    logic [1:0]        ready;

    // A lone valid wins outright; the pointer only breaks ties.
    always_comb begin
        grant = ptr_reg;
        case (bus.req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            default: grant = ptr_reg;
        endcase
    end

    assign idle = (state_reg == IDLE);

    // Ready is purely a function of state, pointer and valids (never of
    // rsp_ready) and is held low while reset is asserted.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
        assign ready[gi] = rst_n & idle & bus.req_valid[gi] & (grant == 1'(gi));
    end

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        cnt_next       = cnt_reg;
        alu_instr_next = alu_instr_reg;
        alu_in1_next   = alu_in1_reg;
        alu_imm_next   = alu_imm_reg;
        rsp_data_next  = rsp_data_reg;
        rsp_id_next    = rsp_id_reg;
        rsp_valid_next = rsp_valid_reg;

        case (state_reg)
            IDLE: begin
                if (|ready) begin
                    alu_instr_next = grant ? bus.req1_instr : bus.req0_instr;
                    alu_in1_next   = grant ? bus.req1_rs1   : bus.req0_rs1;
                    alu_imm_next   = grant ? bus.req1_imm   : bus.req0_imm;
                    rsp_id_next    = grant;
                    // Priority only rotates on an actual accept.
                    ptr_next       = ~grant;
                    cnt_next       = EXEC_LOAD;
                    state_next     = EXEC;
                end
            end
            EXEC: begin
                if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    rsp_data_next  = bus.alu_out;
                    rsp_valid_next = 1'b1;
                    state_next     = RESP;
                end
            end
            RESP: begin
                // No bypass: a new accept waits for the next IDLE cycle.
                if (bus.rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ptr_reg       <= 1'b0;
            cnt_reg       <= 4'd0;
            alu_instr_reg <= '0;
            alu_in1_reg   <= '0;
            alu_imm_reg   <= '0;
            rsp_data_reg  <= '0;
            rsp_id_reg    <= 1'b0;
            rsp_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            cnt_reg       <= cnt_next;
            alu_instr_reg <= alu_instr_next;
            alu_in1_reg   <= alu_in1_next;
            alu_imm_reg   <= alu_imm_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_id_reg    <= rsp_id_next;
            rsp_valid_reg <= rsp_valid_next;
        end
    end

    assign bus.req_ready = ready;
    assign bus.alu_instr = alu_instr_reg;
    assign bus.alu_in1   = alu_in1_reg;
    assign bus.alu_imm   = alu_imm_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_id    = rsp_id_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.busy      = ~idle;

endmodule

// File: tb/tb_imm_alu_arbiter.sv
// tb_imm_alu_arbiter
// Two arbiters (EXEC_CYCLES = 1 and 3) each driving a bench-side RV32I
// immediate ALU. A transaction-level model (accept time, owner, operands)
// predicts every output on every falling edge; directed sequences add
// hand-computed literal expectations, then a randomized phase runs.
module tb_imm_alu_arbiter;

    localparam logic [31:0] ADDI_M3 = 32'hFFD08113; // addi x2,x1,-3
    localparam logic [31:0] ORI_0F  = 32'h00F0E113; // ori  x2,x1,0x00F
    localparam logic [31:0] SRAI_4  = 32'h4040D113; // srai x2,x1,4
    localparam logic [31:0] XORI_FF = 32'h0FF0C113; // xori x2,x1,0x0FF
    localparam logic [31:0] ANDI_1  = 32'h0010F113; // andi x2,x1,1

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // stimulus, indexed [instance][requester]
    logic [1:0]  s_valid [2];
    logic [31:0] s_instr [2][2];
    logic [31:0] s_rs1   [2][2];
    logic [31:0] s_imm   [2][2];
    logic        s_rready[2];

    // observed outputs
    logic [1:0]  o_ready [2];
    logic [31:0] o_ainstr[2], o_ain1[2], o_aimm[2], o_rdata[2];
    logic        o_rvalid[2], o_rid[2], o_busy[2];

    function automatic logic [31:0] alu_f(logic [31:0] ins, logic [31:0] a, logic [31:0] b);
        case (ins[14:12])
            3'b000:  return a + b;
            3'b010:  return {31'b0, $signed(a) < $signed(b)};
            3'b011:  return {31'b0, a < b};
            3'b100:  return a ^ b;
            3'b110:  return a | b;
            3'b111:  return a & b;
            3'b001:  return a << b[4:0];
            3'b101:  return ins[30] ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    imm_alu_arbiter_if #(.DATA_W(32)) bus0 ();
    imm_alu_arbiter_if #(.DATA_W(32)) bus1 ();

    imm_alu_arbiter #(.DATA_W(32), .EXEC_CYCLES(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    imm_alu_arbiter #(.DATA_W(32), .EXEC_CYCLES(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    assign bus0.req_valid  = s_valid[0];
    assign bus0.req0_instr = s_instr[0][0];
    assign bus0.req0_rs1   = s_rs1[0][0];
    assign bus0.req0_imm   = s_imm[0][0];
    assign bus0.req1_instr = s_instr[0][1];
    assign bus0.req1_rs1   = s_rs1[0][1];
    assign bus0.req1_imm   = s_imm[0][1];
    assign bus0.rsp_ready  = s_rready[0];
    assign bus0.alu_out    = alu_f(bus0.alu_instr, bus0.alu_in1, bus0.alu_imm);
    assign bus1.req_valid  = s_valid[1];
    assign bus1.req0_instr = s_instr[1][0];
    assign bus1.req0_rs1   = s_rs1[1][0];
    assign bus1.req0_imm   = s_imm[1][0];
    assign bus1.req1_instr = s_instr[1][1];
    assign bus1.req1_rs1   = s_rs1[1][1];
    assign bus1.req1_imm   = s_imm[1][1];
    assign bus1.rsp_ready  = s_rready[1];
    assign bus1.alu_out    = alu_f(bus1.alu_instr, bus1.alu_in1, bus1.alu_imm);

    assign o_ready[0]  = bus0.req_ready;  assign o_ready[1]  = bus1.req_ready;
    assign o_ainstr[0] = bus0.alu_instr;  assign o_ainstr[1] = bus1.alu_instr;
    assign o_ain1[0]   = bus0.alu_in1;    assign o_ain1[1]   = bus1.alu_in1;
    assign o_aimm[0]   = bus0.alu_imm;    assign o_aimm[1]   = bus1.alu_imm;
    assign o_rdata[0]  = bus0.rsp_data;   assign o_rdata[1]  = bus1.rsp_data;
    assign o_rvalid[0] = bus0.rsp_valid;  assign o_rvalid[1] = bus1.rsp_valid;
    assign o_rid[0]    = bus0.rsp_id;     assign o_rid[1]    = bus1.rsp_id;
    assign o_busy[0]   = bus0.busy;       assign o_busy[1]   = bus1.busy;

    task automatic chk(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %h expected %h (t=%0t)", k, name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // An operation is "in flight" from its accept until its response is
    // consumed; the response appears EXEC+1 cycles after the accept cycle.
    bit          m_inflight[2];
    bit          m_resp[2];
    int          m_acc_t[2];
    bit          m_ptr[2];
    bit          m_id[2];
    logic [31:0] m_instr[2], m_in1[2], m_imm[2], m_rdata[2];
    bit          acc_flag[2][2];
    int          q0[$];

    task automatic model_step(input int k);
        logic [1:0] rv;
        logic [1:0] er;
        bit         g;
        int         ex;
        ex = (k == 0) ? 1 : 3;
        rv = s_valid[k];
        if (!rst_n) begin
            m_inflight[k] = 0; m_resp[k] = 0; m_ptr[k] = 0; m_id[k] = 0;
            m_instr[k] = 0; m_in1[k] = 0; m_imm[k] = 0; m_rdata[k] = 0;
            chk(k, "rst_ready", 32'(o_ready[k]), 32'd0);
            chk(k, "rst_rsp_valid", 32'(o_rvalid[k]), 32'd0);
            chk(k, "rst_busy", 32'(o_busy[k]), 32'd0);
            chk(k, "rst_alu_instr", o_ainstr[k], 32'd0);
            chk(k, "rst_rsp_data", o_rdata[k], 32'd0);
            chk(k, "rst_rsp_id", 32'(o_rid[k]), 32'd0);
            return;
        end
        if (m_inflight[k] && !m_resp[k] && cyc == m_acc_t[k] + 1 + ex) begin
            m_resp[k]  = 1;
            m_rdata[k] = alu_f(m_instr[k], m_in1[k], m_imm[k]);
        end
        g  = (rv == 2'b10) ? 1'b1 : (rv == 2'b01) ? 1'b0 : m_ptr[k];
        er = 2'b00;
        if (!m_inflight[k] && rv != 2'b00) er = g ? 2'b10 : 2'b01;

        chk(k, "req_ready", 32'(o_ready[k]), 32'(er));
        chk(k, "busy", 32'(o_busy[k]), 32'(m_inflight[k]));
        chk(k, "rsp_valid", 32'(o_rvalid[k]), 32'(m_resp[k]));
        chk(k, "rsp_id", 32'(o_rid[k]), 32'(m_id[k]));
        chk(k, "rsp_data", o_rdata[k], m_rdata[k]);
        chk(k, "alu_instr", o_ainstr[k], m_instr[k]);
        chk(k, "alu_in1", o_ain1[k], m_in1[k]);
        chk(k, "alu_imm", o_aimm[k], m_imm[k]);

        if (m_resp[k] && s_rready[k]) begin
            m_resp[k] = 0;
            m_inflight[k] = 0;
            if (k == 0) q0.push_back(int'(m_id[0]));
        end else if (er != 2'b00) begin
            m_inflight[k] = 1;
            m_acc_t[k]    = cyc;
            m_instr[k]    = s_instr[k][g];
            m_in1[k]      = s_rs1[k][g];
            m_imm[k]      = s_imm[k][g];
            m_id[k]       = g;
            m_ptr[k]      = !g;
            acc_flag[k][g] = 1;
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) model_step(k);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int k, input int i, input logic [31:0] ins,
                           input logic [31:0] a, input logic [31:0] b);
        s_instr[k][i] = ins;
        s_rs1[k][i]   = a;
        s_imm[k][i]   = b;
        s_valid[k][i] = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_valid[0] = 2'b00;
        s_valid[1] = 2'b00;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_resp(input int k, input int budget);
        bit ok;
        ok = 0;
        for (int n = 0; n < budget; n++) begin
            if (o_rvalid[k]) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) chk(k, "rsp_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    bit          never11;
    bit          pend[2][2];
    logic [31:0] held_data;

    initial begin
        rst_n = 1'b1;
        s_valid[0] = 2'b00; s_valid[1] = 2'b00;
        s_rready[0] = 1'b1; s_rready[1] = 1'b1;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 2; i++) begin
                s_instr[k][i] = 32'd0; s_rs1[k][i] = 32'd0; s_imm[k][i] = 32'd0;
            end
        #1;
        do_reset();

        // single addi: 5 + (-3) = 2
        set_req(0, 0, ADDI_M3, 32'd5, 32'hFFFF_FFFD);
        #1;
        chk(0, "addi_ready", 32'(o_ready[0]), 32'd1);
        tick();
        s_valid[0] = 2'b00;
        chk(0, "addi_valid_early", 32'(o_rvalid[0]), 32'd0);
        tick();
        chk(0, "addi_valid", 32'(o_rvalid[0]), 32'd1);
        chk(0, "addi_data", o_rdata[0], 32'd2);
        chk(0, "addi_id", 32'(o_rid[0]), 32'd0);
        tick();

        // contention: both valid held, accept order alternates from 0
        do_reset();
        q0.delete();
        never11 = 0;
        set_req(0, 0, ADDI_M3, 32'd10, 32'd1);
        set_req(0, 1, ADDI_M3, 32'd20, 32'd2);
        for (int n = 0; n < 60 && q0.size() < 4; n++) begin
            if (o_ready[0] == 2'b11) never11 = 1;
            tick();
        end
        s_valid[0] = 2'b00;
        chk(0, "cont_count", 32'(q0.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk(0, "cont_id", (i < q0.size()) ? 32'(q0[i]) : 32'hFFFF_FFFF, 32'(i % 2));
        chk(0, "cont_ready11", 32'(never11), 32'd0);
        repeat (4) tick();

        // response backpressure
        do_reset();
        s_rready[0] = 1'b0;
        set_req(0, 1, XORI_FF, 32'h0000_0F0F, 32'h0000_00FF);
        tick();
        s_valid[0] = 2'b00;
        wait_resp(0, 10);
        held_data = o_rdata[0];
        chk(0, "bp_data", held_data, 32'h0000_0FF0);
        set_req(0, 0, ANDI_1, 32'h3, 32'h1);
        for (int n = 0; n < 5; n++) begin
            chk(0, "bp_valid", 32'(o_rvalid[0]), 32'd1);
            chk(0, "bp_ready", 32'(o_ready[0]), 32'd0);
            chk(0, "bp_hold_data", o_rdata[0], 32'h0000_0FF0);
            chk(0, "bp_hold_id", 32'(o_rid[0]), 32'd1);
            tick();
        end
        s_rready[0] = 1'b1;
        #1;
        chk(0, "bp_ready_same", 32'(o_ready[0]), 32'd0);
        tick();
        chk(0, "bp_resume", 32'(o_ready[0]), 32'd1);
        tick();
        s_valid[0] = 2'b00;
        wait_resp(0, 10);
        chk(0, "andi_data", o_rdata[0], 32'd1);
        tick();

        // EXEC_CYCLES=3: ori 0x0F0 | 0x00F
        set_req(1, 0, ORI_0F, 32'h0000_00F0, 32'h0000_000F);
        #1;
        chk(1, "ori_ready", 32'(o_ready[1]), 32'd1);
        tick();
        s_valid[1] = 2'b00;
        for (int n = 0; n < 3; n++) begin
            chk(1, "ori_in1_hold", o_ain1[1], 32'h0000_00F0);
            chk(1, "ori_imm_hold", o_aimm[1], 32'h0000_000F);
            chk(1, "ori_valid_early", 32'(o_rvalid[1]), 32'd0);
            tick();
        end
        chk(1, "ori_valid", 32'(o_rvalid[1]), 32'd1);
        chk(1, "ori_data", o_rdata[1], 32'h0000_00FF);
        tick();

        // reset during EXEC aborts silently, priority returns to 0
        set_req(1, 0, ADDI_M3, 32'd7, 32'd8);
        tick();
        rst_n = 1'b0;
        #1;
        chk(1, "mid_rst_valid", 32'(o_rvalid[1]), 32'd0);
        chk(1, "mid_rst_busy", 32'(o_busy[1]), 32'd0);
        chk(1, "mid_rst_ready", 32'(o_ready[1]), 32'd0);
        tick();
        s_valid[1] = 2'b00;
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk(1, "no_stale", 32'(o_rvalid[1]), 32'd0);
        set_req(1, 0, ADDI_M3, 32'd1, 32'd2);
        set_req(1, 1, ADDI_M3, 32'd3, 32'd4);
        #1;
        chk(1, "post_rst_ptr", 32'(o_ready[1]), 32'd1);
        tick();
        s_valid[1] = 2'b00;
        wait_resp(1, 10);
        tick();

        // passthrough srai
        set_req(0, 0, SRAI_4, 32'h8000_0000, 32'd4);
        tick();
        s_valid[0] = 2'b00;
        chk(0, "srai_instr", o_ainstr[0], SRAI_4);
        tick();
        chk(0, "srai_valid", 32'(o_rvalid[0]), 32'd1);
        chk(0, "srai_data", o_rdata[0], 32'hF800_0000);
        tick();

        // randomized traffic
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 2; i++) begin
                acc_flag[k][i] = 0;
                pend[k][i] = 0;
            end
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 2; i++) begin
                    if (acc_flag[k][i]) begin
                        acc_flag[k][i] = 0;
                        pend[k][i] = 0;
                    end
                    if (!pend[k][i] && $urandom_range(0, 2) == 0) begin
                        pend[k][i]    = 1;
                        s_instr[k][i] = $urandom;
                        s_rs1[k][i]   = $urandom;
                        s_imm[k][i]   = $urandom;
                    end
                    s_valid[k][i] = pend[k][i];
                end
                s_rready[k] = ($urandom_range(0, 3) != 0);
            end
            tick();
        end
        s_valid[0] = 2'b00;
        s_valid[1] = 2'b00;
        s_rready[0] = 1'b1;
        s_rready[1] = 1'b1;
        repeat (8) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
